pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the `enable` inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and their synchronous flush (bubble) inputs. It resolves four conditions:
- load-use hazards;
- taken branches resolved in EX;
- jumps decoded in ID;
- multi-cycle data-memory accesses, with a watchdog.

It sits beside the datapath and is the only source of pipeline-register enables.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of cycles spent in MEM_WAIT before the access is abandoned (range 1..255).

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `id_rs`  in  5  rs field of the instruction in IF/ID
- `id_rt`  in  5  rt field of the instruction in IF/ID
- `id_uses_rt`  in  1  the IF/ID instruction reads rt as a source
- `id_jump`  in  1  the IF/ID instruction is a jump
- `ex_mem_read`  in  1  MemRead of the instruction in ID/EX
- `ex_rd`  in  5  destination register of the instruction in ID/EX
- `ex_branch_taken`  in  1  branch in EX resolved taken
- `mem_req`  in  1  the EX/MEM instruction reads or writes data memory
- `dmem_ready`  in  1  data memory completes the access this cycle
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register enables
- `ifid_flush`, `idex_flush`  out  1 each  load a bubble (all-zero IR and controls) at the next edge
- `ctrl_state`  out  2  current FSM state (0 = RUN, 1 = MEM_WAIT)
- `mem_error`  out  1  sticky flag: a memory access timed out
- `stall_cycles`  out  32  performance counter
- `flush_count`  out  16  performance counter

## Operation
- **Outputs.** All outputs are combinational from state and inputs (Mealy), except `ctrl_state`, `mem_error` and the counters, which are registered.
- **Default, RUN with no hazard:** all enables 1, both flushes 0.
- **Priority, highest first:** memory wait > taken branch > load-use > jump.
- **Memory wait:**
  - In RUN, `mem_req & !dmem_ready` drives all five enables to 0 and suppresses both flushes. Next state is MEM_WAIT.
  - In MEM_WAIT, all enables stay 0 and flushes are suppressed until `dmem_ready` = 1.
  - In the cycle `dmem_ready` = 1, enables and flushes are evaluated exactly as in RUN, and the next state is RUN.
- **Timeout:**
  - A wait counter (8-bit) is cleared on entry to MEM_WAIT and increments every MEM_WAIT cycle.
  - If the counter equals `MEM_TIMEOUT - 1` while `dmem_ready` = 0, `mem_error` is set. In that cycle the outputs are evaluated as in the release cycle, and the next state is RUN.
- **Taken branch:** `ifid_flush` = 1, `idex_flush` = 1; all enables 1.
- **Load-use hazard:**
  - Condition: `ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt))`.
  - Response: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1; `idex_en`, `exmem_en`, `memwb_en` = 1.
  - Exactly one bubble is inserted per hazard.
- **Jump:** `ifid_flush` = 1; all enables 1. A jump held by a load-use stall is not flushed until the stall clears.
- **Re-evaluation after a wait:** a branch or hazard that is present during MEM_WAIT is re-evaluated in the release cycle, because EX is frozen and its inputs are held.

## Timing
- Stall and flush decisions have zero-cycle latency; they are effective at the next rising edge.
- A memory access with `dmem_ready` first high N cycles after `mem_req` freezes the pipeline for exactly N cycles.
- A load-use stall costs 1 cycle. A taken branch costs 2 bubbles. A jump costs 1 bubble.
- **While `reset` is high:**
  - All enables 0; `ifid_flush` = `idex_flush` = 1, so the bubble registers clear at each edge.
  - Next state RUN; wait counter 0; `mem_error` 0; counters 0.
- **Reset during MEM_WAIT:** the access is abandoned, with no error flagged.
- **`mem_error`:** cleared only by reset.

## Configuration
- Macro `PIPE_PERF_CNT_EN`.
- **Defined:**
  - `stall_cycles` increments in every non-reset cycle with `pc_en` = 0 and wraps at 2^32.
  - `flush_count` increments in every non-reset cycle with `ifid_flush | idex_flush` and wraps at 2^16.
- **Undefined:** both counter outputs are tied to 0 and no counter flops exist.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs`=5 for one cycle → `pc_en`=0, `ifid_en`=0, `idex_flush`=1, other enables 1; with `ex_rd`=0 → no stall.
- **Memory wait:** `mem_req`=1 with `dmem_ready` rising on the 4th cycle → enables 0 for 3 cycles and 1 on the 4th; `ctrl_state` 1,1,1 then 0.
- **Branch during wait:** `ex_branch_taken`=1 during a 2-cycle wait → no flush while waiting; `ifid_flush`=`idex_flush`=1 in the release cycle.
- **Timeout:** `MEM_TIMEOUT`=8 with `dmem_ready` held 0 → `mem_error`=1 after the 8th wait cycle, state RUN, flag persists until reset.
- **Reset mid-wait:** `reset`=1 in the 3rd MEM_WAIT cycle → next cycle `ctrl_state`=0, `mem_error`=0, flushes 1 while reset is held.
- **Counters (`PIPE_PERF_CNT_EN`):** 3 load-use stalls plus 2 taken branches → `stall_cycles`=3, `flush_count`=5.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Sole source of the pipeline-register enables and bubble (flush) requests.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   id_rs, id_rt         source register fields of the IF/ID instruction
//   id_uses_rt, id_jump  IF/ID reads rt / IF/ID is a jump
//   ex_mem_read, ex_rd   load flag and destination of the ID/EX instruction
//   ex_branch_taken      branch in EX resolved taken
//   mem_req, dmem_ready  EX/MEM data-memory access and its completion
//   *_en, *_flush        register enables and bubble requests (Mealy)
//   ctrl_state           0 = RUN, 1 = MEM_WAIT (registered)
//   mem_error            sticky data-memory timeout flag
//   stall_cycles,
//   flush_count          performance counters
//
// Parameter MEM_TIMEOUT (1..255) bounds the number of MEM_WAIT cycles.
// Define PIPE_PERF_CNT_EN to build the performance counters; otherwise
// both counter outputs are tied to zero.

module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  ctrl_state,
    output logic        mem_error,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_error_q, mem_error_d;
    logic       hold;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) ||
                       (id_uses_rt && (ex_rd == id_rt)));

    // Next state. `hold` freezes the whole pipeline; when a wait ends
    // (data returned or timed out) hazards are evaluated as in RUN,
    // since EX has been frozen with its inputs held.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        hold        = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    hold       = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WaitLast) begin
                    mem_error_d = 1'b1;
                    state_d     = RUN;
                end else begin
                    hold       = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Enables and flushes, highest priority first.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hold) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Bubble into EX clears ex_mem_read, so one bubble per hazard.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign ctrl_state = state_q;
    assign mem_error  = mem_error_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (ifid_flush || idex_flush) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Directed scenarios followed by randomized traffic against a reference model.

module tb_pipe_hazard_ctrl;

    localparam int TO = 8;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, id_jump, ex_mem_read;
    logic        ex_branch_taken, mem_req, dmem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush;
    logic [1:0]  ctrl_state;
    logic        mem_error;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock),
        .reset(reset),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rt(id_uses_rt),
        .id_jump(id_jump),
        .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en),
        .ifid_en(ifid_en),
        .idex_en(idex_en),
        .exmem_en(exmem_en),
        .memwb_en(memwb_en),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .ctrl_state(ctrl_state),
        .mem_error(mem_error),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  en;
        logic [1:0]  fl;
        logic [1:0]  st;
        logic        err;
        logic [31:0] sc;
        logic [15:0] fc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Reference model: is a memory access outstanding, how many wait
    // cycles it has consumed, the sticky error, and event totals.
    bit          m_waiting = 0;
    int          m_waited  = 0;
    bit          m_err     = 0;
    int unsigned m_stalls  = 0;
    logic [15:0] m_flushes = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req, input int cyc);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, req);
        end
    endtask

    task automatic model_cycle();
        exp_t e;
        bit   frozen;
        bit   lu;
        e.cyc = cyc_n;
        e.st  = m_waiting ? 2'd1 : 2'd0;
        e.err = m_err;
`ifdef PIPE_PERF_CNT_EN
        e.sc = m_stalls;
        e.fc = m_flushes;
`else
        e.sc = 32'd0;
        e.fc = 16'd0;
`endif
        e.en = 5'b11111;
        e.fl = 2'b00;
        frozen = 0;
        lu = ex_mem_read && ex_rd != 0 &&
             (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        if (reset) begin
            e.en = 5'b00000;
            e.fl = 2'b11;
            m_waiting = 0;
            m_waited  = 0;
            m_err     = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (!m_waiting) begin
                if (mem_req && !dmem_ready) begin
                    frozen = 1;
                    m_waiting = 1;
                    m_waited = 0;
                end
            end else if (dmem_ready) begin
                m_waiting = 0;
            end else if (m_waited + 1 == TO) begin
                m_err = 1;
                m_waiting = 0;
            end else begin
                frozen = 1;
                m_waited++;
            end
            if (frozen) begin
                e.en = 5'b00000;
            end else if (ex_branch_taken) begin
                e.fl = 2'b11;
            end else if (lu) begin
                e.en = 5'b00111;
                e.fl = 2'b01;
            end else if (id_jump) begin
                e.fl = 2'b10;
            end
            if (e.en[4] == 1'b0) m_stalls++;
            if (e.fl != 2'b00) m_flushes++;
        end
        q.push_back(e);
        cyc_n++;
    endtask

    task automatic step(input logic r, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt,
                        input logic jmp, input logic mrd,
                        input logic [4:0] rd, input logic br,
                        input logic mreq, input logic rdy);
        @(posedge clock);
        #1;
        reset = r;
        id_rs = rs;
        id_rt = rt;
        id_uses_rt = urt;
        id_jump = jmp;
        ex_mem_read = mrd;
        ex_rd = rd;
        ex_branch_taken = br;
        mem_req = mreq;
        dmem_ready = rdy;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("enables",
                    {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en},
                    {27'd0, e.en}, e.cyc);
                chk("flushes", {30'd0, ifid_flush, idex_flush},
                    {30'd0, e.fl}, e.cyc);
                chk("ctrl_state", {30'd0, ctrl_state}, {30'd0, e.st}, e.cyc);
                chk("mem_error", {31'd0, mem_error}, {31'd0, e.err}, e.cyc);
                chk("stall_cycles", stall_cycles, e.sc, e.cyc);
                chk("flush_count", {16'd0, flush_count}, {16'd0, e.fc}, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        id_rs = 0;
        id_rt = 0;
        id_uses_rt = 0;
        id_jump = 0;
        ex_mem_read = 0;
        ex_rd = 0;
        ex_branch_taken = 0;
        mem_req = 0;
        dmem_ready = 0;

        // reset state
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        idle(2);

        // load-use on rs, on rt, rt unused, and rd = 0
        step(0, 5'd5, 5'd2, 0, 0, 1, 5'd5, 0, 0, 0);
        step(0, 5'd3, 5'd7, 1, 0, 1, 5'd7, 0, 0, 0);
        step(0, 5'd3, 5'd7, 0, 0, 1, 5'd7, 0, 0, 0);
        step(0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0);
        // jump, jump held by load-use, branch over load-use
        step(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0, 0);
        step(0, 5'd4, 5'd2, 0, 1, 1, 5'd4, 0, 0, 0);
        step(0, 5'd4, 5'd2, 0, 1, 1, 5'd4, 1, 0, 0);
        idle(1);

        // memory wait: ready on the 4th cycle
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 1);
        idle(1);

        // branch during a 2-cycle wait
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 1);
        idle(1);

        // timeout: entry plus TO wait cycles, flag persists
        for (int i = 0; i < TO + 1; i++)
            step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        idle(3);
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        idle(1);

        // reset in the 3rd wait cycle
        for (int i = 0; i < 3; i++)
            step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        step(1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        step(1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
        idle(2);

        // counters: 3 load-use stalls and 2 taken branches after reset
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 5'd6, 5'd2, 0, 0, 1, 5'd6, 0, 0, 0);
            idle(1);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, 0);
            idle(1);
        end
        idle(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0),
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 1'($urandom_range(1)), ($urandom_range(4) == 0),
                 ($urandom_range(2) == 0), 5'($urandom_range(3)),
                 ($urandom_range(5) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(2) == 0));
        end

        @(negedge clock);
        #1;
        chk("scoreboard_drained", q.size(), 0, cyc_n);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
